// File: rtl/mem_rr_scheduler_if.sv
// Bundle of request, memory and response signals shared by mem_rr_scheduler
// and whatever drives it. Per-port fields are flattened, port k occupying
// slice [k*W +: W].
// slave  : the scheduler's view.
// master : the view of the clients and memory.
interface mem_rr_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 1,
    parameter int PORTS      = 2
);
    logic [PORTS-1:0]            req_valid;
    logic [PORTS-1:0]            req_ready;
    logic [PORTS-1:0]            req_read_enable;
    logic [PORTS*MASK_WIDTH-1:0] req_write_enable;
    logic [PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [PORTS*DATA_WIDTH-1:0] req_data;

    logic                        mem_out_valid;
    logic                        mem_out_ready;
    logic                        mem_out_read_enable;
    logic [MASK_WIDTH-1:0]       mem_out_write_enable;
    logic [ADDR_WIDTH-1:0]       mem_out_addr;
    logic [DATA_WIDTH-1:0]       mem_out_data;
    logic [ID_WIDTH-1:0]         mem_out_id;

    logic                        mem_in_valid;
    logic                        mem_in_ready;
    logic [DATA_WIDTH-1:0]       mem_in_data;
    logic [ID_WIDTH-1:0]         mem_in_id;

    logic [PORTS-1:0]            rsp_valid;
    logic [PORTS-1:0]            rsp_ready;
    logic [PORTS*DATA_WIDTH-1:0] rsp_data;

    logic                        err_id;

    modport slave (
        input  req_valid, req_read_enable, req_write_enable, req_addr, req_data,
        output req_ready,
        output mem_out_valid, mem_out_read_enable, mem_out_write_enable,
        output mem_out_addr, mem_out_data, mem_out_id,
        input  mem_out_ready,
        input  mem_in_valid, mem_in_data, mem_in_id,
        output mem_in_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output err_id
    );

    modport master (
        output req_valid, req_read_enable, req_write_enable, req_addr, req_data,
        input  req_ready,
        input  mem_out_valid, mem_out_read_enable, mem_out_write_enable,
        input  mem_out_addr, mem_out_data, mem_out_id,
        output mem_out_ready,
        output mem_in_valid, mem_in_data, mem_in_id,
        input  mem_in_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  err_id
    );
endinterface

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one memory port between PORTS requesters.
// It has a single registered request slot, tracks per-port read credits, and
// routes each response back to its owner by id.
// Optional feature: define MEM_SCHED_PRIORITY_EN to give port 0 strict priority.
// Port-0 grants then leave the round-robin pointer alone. The other ports
// share the pointer.
module mem_rr_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 1,
    parameter int PORTS           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_scheduler_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

`ifdef MEM_SCHED_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q [PORTS];
    logic [CW-1:0]         cnt_d [PORTS];
    logic                  mem_out_valid_q, mem_out_valid_d;
    logic                  mem_out_read_enable_q, mem_out_read_enable_d;
    logic [MASK_WIDTH-1:0] mem_out_write_enable_q, mem_out_write_enable_d;
    logic [ADDR_WIDTH-1:0] mem_out_addr_q, mem_out_addr_d;
    logic [DATA_WIDTH-1:0] mem_out_data_q, mem_out_data_d;
    logic [ID_WIDTH-1:0]   mem_out_id_q, mem_out_id_d;
    logic                  err_id_q, err_id_d;

    logic [PORTS-1:0]      elig;
    logic                  grant_found;
    logic [PW-1:0]         grant_idx;
    logic                  load;
    logic                  accept;
    logic [PORTS-1:0]      req_ready;
    logic [PORTS-1:0]      rsp_valid;
    logic [PORTS-1:0]      rsp_fire;
    logic                  mem_in_ready;
    logic                  id_bad;

    // A port may compete unless it is a read and its credits are exhausted.
    always_comb begin
        elig = '0;
        for (int k = 0; k < PORTS; k++) begin
            elig[k] = bus.req_valid[k] &&
                      (!bus.req_read_enable[k] || (cnt_q[k] < CW'(MAX_OUTSTANDING)));
        end
    end

    // Grant the first eligible port found from ptr upwards. In priority mode
    // port 0 wins outright and is skipped by the rotating search.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (PRIO_EN && elig[0]) begin
            grant_found = 1'b1;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                idx = (int'(ptr_q) + i) % PORTS;
                if (!grant_found && elig[idx] && !(PRIO_EN && idx == 0)) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(idx);
                end
            end
        end
    end

    // The slot reloads whenever it is empty or draining. The granted payload
    // is captured on load and held otherwise.
    always_comb begin
        load   = !mem_out_valid_q || bus.mem_out_ready;
        accept = load && grant_found;

        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end

        mem_out_valid_d        = mem_out_valid_q;
        mem_out_read_enable_d  = mem_out_read_enable_q;
        mem_out_write_enable_d = mem_out_write_enable_q;
        mem_out_addr_d         = mem_out_addr_q;
        mem_out_data_d         = mem_out_data_q;
        mem_out_id_d           = mem_out_id_q;
        if (load) begin
            mem_out_valid_d = grant_found;
            if (grant_found) begin
                mem_out_read_enable_d  = bus.req_read_enable[grant_idx];
                mem_out_write_enable_d = bus.req_write_enable[int'(grant_idx)*MASK_WIDTH +: MASK_WIDTH];
                mem_out_addr_d         = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_out_data_d         = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                mem_out_id_d           = ID_WIDTH'(grant_idx);
            end
        end

        ptr_d = ptr_q;
        if (accept && !(PRIO_EN && grant_idx == '0)) begin
            ptr_d = (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Steer the response to its owner. An id with no owner is swallowed so
    // the memory never stalls on it.
    always_comb begin
        rsp_valid    = '0;
        rsp_fire     = '0;
        mem_in_ready = 1'b1;
        id_bad       = 1'b1;
        for (int k = 0; k < PORTS; k++) begin
            if (int'(bus.mem_in_id) == k) begin
                id_bad       = 1'b0;
                rsp_valid[k] = bus.mem_in_valid;
                mem_in_ready = bus.rsp_ready[k];
                rsp_fire[k]  = bus.mem_in_valid && bus.rsp_ready[k];
            end
        end
    end

    // Credit counters saturate at zero. A response with no credit to return
    // is still delivered, but it raises the sticky error flag.
    always_comb begin
        logic inc;
        err_id_d = err_id_q;
        inc      = 1'b0;
        if (bus.mem_in_valid && id_bad) begin
            err_id_d = 1'b1;
        end
        for (int k = 0; k < PORTS; k++) begin
            inc      = accept && (int'(grant_idx) == k) && bus.req_read_enable[k];
            cnt_d[k] = cnt_q[k];
            if (rsp_fire[k] && cnt_q[k] == '0) begin
                err_id_d = 1'b1;
            end
            if (inc && !rsp_fire[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (rsp_fire[k] && !inc && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
    end

    // All scheduler state; an asynchronous reset drops any held request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q                  <= '0;
            mem_out_valid_q        <= 1'b0;
            mem_out_read_enable_q  <= 1'b0;
            mem_out_write_enable_q <= '0;
            mem_out_addr_q         <= '0;
            mem_out_data_q         <= '0;
            mem_out_id_q           <= '0;
            err_id_q               <= 1'b0;
            for (int k = 0; k < PORTS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            ptr_q                  <= ptr_d;
            mem_out_valid_q        <= mem_out_valid_d;
            mem_out_read_enable_q  <= mem_out_read_enable_d;
            mem_out_write_enable_q <= mem_out_write_enable_d;
            mem_out_addr_q         <= mem_out_addr_d;
            mem_out_data_q         <= mem_out_data_d;
            mem_out_id_q           <= mem_out_id_d;
            err_id_q               <= err_id_d;
            for (int k = 0; k < PORTS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.req_ready            = req_ready;
    assign bus.mem_out_valid        = mem_out_valid_q;
    assign bus.mem_out_read_enable  = mem_out_read_enable_q;
    assign bus.mem_out_write_enable = mem_out_write_enable_q;
    assign bus.mem_out_addr         = mem_out_addr_q;
    assign bus.mem_out_data         = mem_out_data_q;
    assign bus.mem_out_id           = mem_out_id_q;
    assign bus.mem_in_ready         = mem_in_ready;
    assign bus.rsp_valid            = rsp_valid;
    assign bus.rsp_data             = {PORTS{bus.mem_in_data}};
    assign bus.err_id               = err_id_q;
endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed bench for mem_rr_scheduler: 3 ports, 2-bit id, 4 read credits per port.
module tb_mem_rr_scheduler;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int IW = 2;
    localparam int P  = 3;
    localparam int MO = 4;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_rr_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                          .ID_WIDTH(IW), .PORTS(P)) bus ();

    mem_rr_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                       .ID_WIDTH(IW), .PORTS(P), .MAX_OUTSTANDING(MO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int k, input logic rd, input logic [MW-1:0] we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_read_enable[k]          = rd;
        bus.req_write_enable[k*MW +: MW] = we;
        bus.req_addr[k*AW +: AW]         = a;
        bus.req_data[k*DW +: DW]         = d;
    endtask

    initial begin
        logic [63:0] exp_id;
        logic [63:0] exp_rdy;

        rst                  = 1'b0;
        bus.req_valid        = '0;
        bus.req_read_enable  = '0;
        bus.req_write_enable = '0;
        bus.req_addr         = '0;
        bus.req_data         = '0;
        bus.mem_out_ready    = 1'b0;
        bus.mem_in_valid     = 1'b0;
        bus.mem_in_data      = '0;
        bus.mem_in_id        = '0;
        bus.rsp_ready        = '0;
        #2;
        check("rst_valid", bus.mem_out_valid, 0);
        check("rst_addr", bus.mem_out_addr, 0);
        check("rst_data", bus.mem_out_data, 0);
        check("rst_we", bus.mem_out_write_enable, 0);
        check("rst_id", bus.mem_out_id, 0);
        check("rst_err", bus.err_id, 0);
        #10;
        rst = 1'b1;

        // Two writers alternate under full throughput.
        set_port(0, 1'b0, 4'hF, 32'h100, 32'hA0);
        set_port(1, 1'b0, 4'h3, 32'h200, 32'hB1);
        bus.req_valid     = 3'b011;
        bus.mem_out_ready = 1'b1;
        settle();
        check("t1_first_ready", bus.req_ready, 3'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", bus.mem_out_valid, 1);
            check("t1_id", bus.mem_out_id, i % 2);
            check("t1_addr", bus.mem_out_addr, (i % 2) ? 32'h200 : 32'h100);
            check("t1_data", bus.mem_out_data, (i % 2) ? 32'hB1 : 32'hA0);
            check("t1_we", bus.mem_out_write_enable, (i % 2) ? 4'h3 : 4'hF);
            check("t1_ready", bus.req_ready, (i % 2) ? 3'b001 : 3'b010);
        end

        // Back-pressure holds the slot.
        bus.mem_out_ready = 1'b0;
        settle();
        check("t2_ready_stall", bus.req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", bus.mem_out_valid, 1);
            check("t2_hold_id", bus.mem_out_id, 1);
            check("t2_hold_addr", bus.mem_out_addr, 32'h200);
            check("t2_hold_data", bus.mem_out_data, 32'hB1);
            check("t2_hold_ready", bus.req_ready, 0);
        end
        bus.mem_out_ready = 1'b1;
        settle();
        check("t2_resume_ready", bus.req_ready, 3'b001);
        tick();
        check("t2_resume_id", bus.mem_out_id, 0);
        check("t2_resume_addr", bus.mem_out_addr, 32'h100);
        bus.req_valid = '0;
        settle();
        check("t2_idle_ready", bus.req_ready, 0);
        tick();
        check("t2_idle_valid", bus.mem_out_valid, 0);

        // Port 1 runs out of read credits.
        set_port(1, 1'b1, 4'h0, 32'h300, 32'h0);
        bus.req_valid = 3'b010;
        settle();
        for (int i = 0; i < 4; i++) begin
            check("t3_rd_ready", bus.req_ready, 3'b010);
            tick();
            check("t3_rd_id", bus.mem_out_id, 1);
            check("t3_rd_re", bus.mem_out_read_enable, 1);
        end
        check("t3_fifth_stall", bus.req_ready, 0);
        set_port(0, 1'b0, 4'hF, 32'h104, 32'hA4);
        bus.req_valid = 3'b011;
        settle();
        check("t3_p0_ready", bus.req_ready, 3'b001);
        tick();
        check("t3_p0_id", bus.mem_out_id, 0);
        check("t3_p0_re", bus.mem_out_read_enable, 0);
        check("t3_p0_addr", bus.mem_out_addr, 32'h104);
        bus.mem_in_valid = 1'b1;
        bus.mem_in_id    = 2'd1;
        bus.mem_in_data  = 32'hD1;
        bus.rsp_ready    = 3'b010;
        settle();
        check("t3_rsp_valid", bus.rsp_valid, 3'b010);
        check("t3_mem_in_ready", bus.mem_in_ready, 1);
        check("t3_rsp_data1", bus.rsp_data[63:32], 32'hD1);
        check("t3_rsp_data2", bus.rsp_data[95:64], 32'hD1);
        check("t3_still_full", bus.req_ready, 3'b001);
        tick();
        bus.mem_in_valid = 1'b0;
        bus.req_valid    = 3'b010;
        settle();
        check("t3_credit_back", bus.req_ready, 3'b010);
        check("t3_err", bus.err_id, 0);
        tick();
        check("t3_p1_again", bus.mem_out_id, 1);
        bus.req_valid = '0;

        // Response stalled by rsp_ready; the credit returns only on handshake.
        bus.mem_in_valid = 1'b1;
        bus.mem_in_id    = 2'd1;
        bus.mem_in_data  = 32'hD2;
        bus.rsp_ready    = 3'b000;
        bus.req_valid    = 3'b010;
        settle();
        check("t4_rsp_valid", bus.rsp_valid, 3'b010);
        check("t4_mi_ready0", bus.mem_in_ready, 0);
        check("t4_no_credit0", bus.req_ready, 0);
        tick();
        check("t4_mi_ready1", bus.mem_in_ready, 0);
        check("t4_no_credit1", bus.req_ready, 0);
        bus.rsp_ready = 3'b010;
        settle();
        check("t4_mi_ready2", bus.mem_in_ready, 1);
        check("t4_no_credit2", bus.req_ready, 0);
        tick();
        bus.mem_in_valid = 1'b0;
        settle();
        check("t4_credit_back", bus.req_ready, 3'b010);
        bus.req_valid = '0;

        // Response with an id that no port owns.
        check("t5_err_before", bus.err_id, 0);
        bus.mem_in_valid = 1'b1;
        bus.mem_in_id    = 2'd3;
        bus.rsp_ready    = 3'b111;
        settle();
        check("t5_mi_ready", bus.mem_in_ready, 1);
        check("t5_no_rsp", bus.rsp_valid, 0);
        tick();
        check("t5_err_set", bus.err_id, 1);
        bus.mem_in_valid = 1'b0;
        tick();
        tick();
        check("t5_err_sticky", bus.err_id, 1);

        // Asynchronous reset while a request is held.
        bus.mem_out_ready = 1'b0;
        set_port(0, 1'b0, 4'hF, 32'h108, 32'hA8);
        bus.req_valid = 3'b001;
        settle();
        check("rst2_ready", bus.req_ready, 3'b001);
        tick();
        check("rst2_held_valid", bus.mem_out_valid, 1);
        check("rst2_held_addr", bus.mem_out_addr, 32'h108);
        bus.req_valid = '0;
        rst = 1'b0;
        settle();
        check("rst2_valid", bus.mem_out_valid, 0);
        check("rst2_addr", bus.mem_out_addr, 0);
        check("rst2_data", bus.mem_out_data, 0);
        check("rst2_err", bus.err_id, 0);
        bus.mem_out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst2_dropped", bus.mem_out_valid, 0);

        // All three ports valid, then port 0 drops out.
        set_port(0, 1'b0, 4'hF, 32'h110, 32'hC0);
        set_port(1, 1'b0, 4'hF, 32'h120, 32'hC1);
        set_port(2, 1'b0, 4'hF, 32'h130, 32'hC2);
        bus.req_valid = 3'b111;
        settle();
        check("t6_first_ready", bus.req_ready, 3'b001);
        for (int i = 0; i < 3; i++) begin
`ifdef MEM_SCHED_PRIORITY_EN
            exp_id  = 0;
            exp_rdy = 3'b001;
`else
            exp_id  = 64'(i);
            exp_rdy = 64'(3'b001 << ((i + 1) % 3));
`endif
            tick();
            check("t6_all_id", bus.mem_out_id, exp_id);
            check("t6_all_ready", bus.req_ready, exp_rdy);
        end
        bus.req_valid = 3'b110;
        settle();
        check("t6_p12_ready", bus.req_ready, 3'b010);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t6_p12_id", bus.mem_out_id, (j % 2) ? 2 : 1);
            check("t6_p12_addr", bus.mem_out_addr, (j % 2) ? 32'h130 : 32'h120);
        end
        bus.req_valid = '0;
        tick();

        // A response to a port holding no credits is delivered but flagged.
        bus.mem_in_valid = 1'b1;
        bus.mem_in_id    = 2'd1;
        bus.mem_in_data  = 32'hE1;
        bus.rsp_ready    = 3'b010;
        settle();
        check("zc_rsp_valid", bus.rsp_valid, 3'b010);
        check("zc_mi_ready", bus.mem_in_ready, 1);
        check("zc_rsp_data", bus.rsp_data[63:32], 32'hE1);
        check("zc_err_before", bus.err_id, 0);
        tick();
        check("zc_err_set", bus.err_id, 1);
        bus.mem_in_valid = 1'b0;

        // The counter stayed at zero: exactly four reads fit again.
        set_port(1, 1'b1, 4'h0, 32'h140, 32'h0);
        bus.req_valid = 3'b010;
        settle();
        for (int i = 0; i < 4; i++) begin
            check("sat_rd_ready", bus.req_ready, 3'b010);
            tick();
        end
        check("sat_fifth_stall", bus.req_ready, 0);
        bus.req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
